alu_muldiv: RTL and testbench

- Multi-cycle RV32M execution unit; consumes the 4-bit aluOp produced by alu_ctrl.
- Executes OP_MU (4'b1001), OP_DIV (4'b1010) and OP_REM (4'b1011). funct3 selects the exact variant.
- Sits beside the single-cycle ALU in EX. Uses a valid/ready handshake on input and output so the pipeline stalls while it iterates.
- Radix-2: shift-add multiply, restoring divide.

---
 rtl/alu_muldiv.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Radix-2 RV32M multiply/divide unit: shift-add multiply and restoring divide on a
// shared 2*XLEN accumulator, with valid/ready handshakes on both sides.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluOp,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [3:0]      OP_MU    = 4'b1001;
    localparam logic [3:0]      OP_DIV   = 4'b1010;
    localparam logic [3:0]      OP_REM   = 4'b1011;
    localparam logic [XLEN-1:0] X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] W_ONE  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + X_ONE) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + W_ONE) : v;
    endfunction

    state_t              state_q,     state_d;
    logic [CW-1:0]       cnt_q,       cnt_d;
    logic [2*XLEN-1:0]   acc_q,       acc_d;
    logic [XLEN-1:0]     op_q,        op_d;
    logic                is_div_q,    is_div_d;
    logic                sel_hi_q,    sel_hi_d;
    logic                neg_lo_q,    neg_lo_d;
    logic                neg_rem_q,   neg_rem_d;
    logic [XLEN-1:0]     result_q,    result_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q,  in_ready_d;

    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_step_s;
    logic [XLEN:0]       div_up_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_sub_s;
    logic [2*XLEN-1:0]   div_step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     fin_s;
    logic                op_ok_s;
    logic                accept_s;
    logic                is_div_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic                neg_a_s;
    logic                neg_b_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic                div0_s;
    logic                ovf_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Iteration datapaths, sign fixup and accept-time operand decode.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
        mul_step_s = {mul_sum_s, acc_q[XLEN-1:1]};

        // Partial remainder never exceeds 2*divisor, so an XLEN-bit subtract suffices once ge holds.
        div_up_s   = acc_q[2*XLEN-1:XLEN-1];
        div_ge_s   = (div_up_s >= {1'b0, op_q});
        div_sub_s  = div_up_s[XLEN-1:0] - op_q;
        div_step_s = {(div_ge_s ? div_sub_s : div_up_s[XLEN-1:0]), acc_q[XLEN-2:0], div_ge_s};

        prod_s = neg_2x(acc_q, neg_lo_q);
        quo_s  = neg_x(acc_q[XLEN-1:0], neg_lo_q);
        rem_s  = neg_x(acc_q[2*XLEN-1:XLEN], neg_rem_q);
        if (is_div_q) begin
            fin_s = sel_hi_q ? rem_s : quo_s;
        end else begin
            fin_s = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end

        op_ok_s  = (aluOp == OP_MU) || (aluOp == OP_DIV) || (aluOp == OP_REM);
        accept_s = in_valid && in_ready_q && op_ok_s && !flush;
        is_div_s = (aluOp != OP_MU);
        sign_a_s = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_b_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a_s  = sign_a_s && src1[XLEN-1];
        neg_b_s  = sign_b_s && src2[XLEN-1];
        mag_a_s  = neg_x(src1, neg_a_s);
        mag_b_s  = neg_x(src2, neg_b_s);
        div0_s   = is_div_s && (src2 == X_ZERO);
        ovf_s    = is_div_s && sign_a_s && sign_b_s && (src1 == X_MIN) && (src2 == X_ONES);
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer and its registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        op_d      = op_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_d   = CALC;
                        is_div_d  = is_div_s;
                        sel_hi_d  = is_div_s ? funct3[1] : (funct3 != 3'b000);
                        neg_lo_d  = neg_a_s ^ neg_b_s;
                        neg_rem_d = neg_a_s;
                        // Special cases preload the final {rem, quo} and skip the iterations.
                        if (div0_s) begin
                            cnt_d     = CNT_ZERO;
                            acc_d     = {src1, X_ONES};
                            neg_lo_d  = 1'b0;
                            neg_rem_d = 1'b0;
                        end else if (ovf_s) begin
                            cnt_d     = CNT_ZERO;
                            acc_d     = {X_ZERO, src1};
                            neg_lo_d  = 1'b0;
                            neg_rem_d = 1'b0;
                        end else if (is_div_s) begin
                            cnt_d = CNT_LOAD;
                            acc_d = {X_ZERO, mag_a_s};
                            op_d  = mag_b_s;
                        end else begin
                            cnt_d = CNT_LOAD;
                            acc_d = {X_ZERO, mag_b_s};
                            op_d  = mag_a_s;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                        acc_d = is_div_q ? div_step_s : mul_step_s;
                    end else begin
                        result_d = fin_s;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            acc_q       <= {(2*XLEN){1'b0}};
            op_q        <= X_ZERO;
            is_div_q    <= 1'b0;
            sel_hi_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= X_ZERO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            is_div_q    <= is_div_d;
            sel_hi_q    <= sel_hi_d;
            neg_lo_q    <= neg_lo_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed RV32M cases, randomized ops against
// an arithmetic reference model, handshake, flush, reset and illegal-op scenarios.
module tb_alu_muldiv;

    localparam logic [3:0] OP_MU  = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_REM = 4'b1011;
    localparam logic [3:0] OP_ADD = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluOp = 4'b0000;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src1 = 32'h0;
    logic [31:0] src2 = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int chk_cnt = 0;
    int pass_cnt = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .funct3(funct3), .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain integer arithmetic on matched aluOp/funct3 pairs.
    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int ia, ib;
        logic [63:0] pb;
        logic [31:0] q, r;
        if (op == OP_MU) begin
            sa = (f3 == 3'b001 || f3 == 3'b010) ? longint'($signed(a)) : longint'(a);
            sb = (f3 == 3'b001) ? longint'($signed(b)) : longint'(b);
            p  = sa * sb;
            pb = p;
            return (f3 == 3'b000) ? pb[31:0] : pb[63:32];
        end
        if (b == 32'h0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = a;
            r = 32'h0;
        end else if (!f3[0]) begin
            ia = a;
            ib = b;
            q  = ia / ib;
            r  = ia % ib;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (op != OP_MU && (b == 32'h0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one op from an IDLE cycle, then counts edges until out_valid (bounded).
    task automatic run_op(input logic [3:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat,
                          output int rdy_errs);
        aluOp = op; funct3 = f3; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        rdy_errs = 0;
        for (int e = 1; e <= 100 && lat < 0; e++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0) rdy_errs++;
            if (out_valid === 1'b1) lat = e;
        end
        res = result;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int lat, rerr;
        logic [2:0] f3s [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] exps [3] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        run_op(OP_MU, 3'b000, 32'd7, 32'hFFFFFFFD, res, lat, rerr);
        chk_cnt++;
        if (res !== 32'hFFFFFFEB) $display("FAIL mul_7x-3: got %h expected ffffffeb", res);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rerr !== 0) $display("FAIL mul_in_ready_busy: got %0d high cycles expected 0", rerr);
        else pass_cnt++;
        pop();
        for (int i = 0; i < 3; i++) begin
            run_op(OP_MU, f3s[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, rerr);
            chk_cnt++;
            if (res !== exps[i]) $display("FAIL mulh_f3_%0d: got %h expected %h", f3s[i], res, exps[i]);
            else pass_cnt++;
            pop();
        end
    endtask

    task automatic test_div();
        logic [31:0] res;
        int lat, rerr;
        logic [3:0]  ops  [7] = '{OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [2:0]  f3s  [7] = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] as   [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5,
                                  32'h80000000, 32'h80000000};
        logic [31:0] bs   [7] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'd5,
                                  32'h80000000, 32'h0};
        int          lats [7] = '{33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], f3s[i], as[i], bs[i], res, lat, rerr);
            chk_cnt++;
            if (res !== exps[i]) $display("FAIL div_case_%0d: got %h expected %h", i, res, exps[i]);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== lats[i]) $display("FAIL div_lat_%0d: got %0d expected %0d", i, lat, lats[i]);
            else pass_cnt++;
            pop();
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp;
        logic [3:0] op;
        logic [2:0] f3;
        int lat, rerr, elat;
        for (int i = 0; i < 60; i++) begin
            a = rand_operand();
            b = rand_operand();
            f3 = 3'($urandom_range(0, 7));
            op = (f3[2] == 1'b0) ? OP_MU : (f3[1] ? OP_REM : OP_DIV);
            exp = ref_model(op, f3, a, b);
            elat = ref_latency(op, f3, a, b);
            run_op(op, f3, a, b, res, lat, rerr);
            chk_cnt++;
            if (res !== exp || lat !== elat)
                $display("FAIL rand_%0d op=%b f3=%b a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, op, f3, a, b, res, lat, exp, elat);
            else pass_cnt++;
            pop();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, held;
        int lat, rerr, errs;
        run_op(OP_DIV, 3'b101, 32'd1000, 32'd7, res, lat, rerr);
        held = res;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) errs++;
        end
        chk_cnt++;
        if (errs !== 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", errs);
        else pass_cnt++;
        chk_cnt++;
        if (held !== 32'd142) $display("FAIL hold_result: got %h expected %h", held, 32'd142);
        else pass_cnt++;
        // Second op presented during the handshake cycle; only accepted once IDLE.
        aluOp = OP_MU; funct3 = 3'b000; src1 = 32'd1234; src2 = 32'd5678;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handshake_idle: got valid %b ready %b expected 0 1", out_valid, in_ready);
        else pass_cnt++;
        run_op(OP_MU, 3'b000, 32'd1234, 32'd5678, res, lat, rerr);
        chk_cnt++;
        if (res !== 32'd7006652 || lat !== 33)
            $display("FAIL back_to_back: got %h lat %0d expected %h lat 33", res, lat, 32'd7006652);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_abort();
        logic [31:0] prev;
        int errs;
        prev = result;
        aluOp = OP_DIV; funct3 = 3'b100; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== prev)
            $display("FAIL flush_calc: got ready %b valid %b result %h expected 1 0 %h",
                     in_ready, out_valid, result, prev);
        else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) errs++;
        end
        chk_cnt++;
        if (errs !== 0) $display("FAIL flush_no_result: got %0d valid cycles expected 0", errs);
        else pass_cnt++;

        aluOp = OP_MU; funct3 = 3'b000; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_mid_calc: got valid %b result %h expected 0 00000000", out_valid, result);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        chk_cnt++;
        if (errs !== 0) $display("FAIL reset_no_result: got %0d bad cycles expected 0", errs);
        else pass_cnt++;

        aluOp = OP_MU; funct3 = 3'b000; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL flush_idle_accept: got ready %b expected 1", in_ready);
        else pass_cnt++;

        aluOp = OP_ADD; funct3 = 3'b000; in_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (errs !== 0) $display("FAIL illegal_op_ignored: got %0d bad cycles expected 0", errs);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
